// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and baud divider rounding.
// Also imported by the matching uart_rx so both ends agree on encodings.
package uart_tx_fifo_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Cycles per bit, rounded to the nearest whole clock.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the oldest word whenever the FIFO is not empty,
// so the consumer takes it in the same cycle it asserts pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a send FIFO: configurable baud, word width, parity and stop count,
// frames sent LSB-first and back-to-back while words are queued.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CW    = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int IDX_W = 4;

    localparam logic [CW-1:0]    DIV_M1    = CW'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state;
    logic [CW-1:0]        baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shifter;
    logic                 parity_bit;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 push;
    logic                 pop;
    logic                 frame_done;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;

    // A word leaves the FIFO either from idle or on the very last stop cycle, so frames abut.
    always_comb begin
        frame_done = (state == ST_STOP) && (baud_cnt == '0) && (bit_idx == LAST_STOP);
        pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (wr_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end

            if (pop) begin
                state      <= ST_START;
                baud_cnt   <= DIV_M1;
                bit_idx    <= '0;
                shifter    <= fifo_dout;
                parity_bit <= (PARITY == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
                tx         <= 1'b0;
                tx_busy    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (baud_cnt == '0) begin
                            state    <= ST_DATA;
                            baud_cnt <= DIV_M1;
                            tx       <= shifter[0];
                            shifter  <= shifter >> 1;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_cnt == '0) begin
                            baud_cnt <= DIV_M1;
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                if (PARITY != PAR_NONE) begin
                                    state <= ST_PARITY;
                                    tx    <= parity_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx      <= shifter[0];
                                shifter <= shifter >> 1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (baud_cnt == '0) begin
                            state    <= ST_STOP;
                            baud_cnt <= DIV_M1;
                            bit_idx  <= '0;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        // Reaching here with the count expired means the FIFO was empty.
                        if (baud_cnt == '0) begin
                            if (bit_idx == LAST_STOP) begin
                                state   <= ST_IDLE;
                                tx      <= 1'b1;
                                tx_busy <= 1'b0;
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                baud_cnt <= DIV_M1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 12 MHz / 1 Mbaud (12 cycles per bit): one 8N1 instance
// plus even-parity/2-stop and odd-parity/1-stop instances for the parity frames.
module tb_uart_tx_fifo;

    localparam logic [8:0] RESET_VEC = 9'b1_0_1_00000_0;

    logic       CLK;
    logic       reset_n;

    logic [7:0] wr_data0, wr_data_e, wr_data_o;
    logic       wr_valid0, wr_valid_e, wr_valid_o;
    logic       wr_ready0, wr_ready_e, wr_ready_o;
    logic       tx0, tx_e, tx_o;
    logic       tx_busy0, tx_busy_e, tx_busy_o;
    logic [4:0] fifo_count0, fifo_count_e, fifo_count_o;
    logic       overflow0, overflow_e, overflow_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    uart_tx_fifo #(
        .CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .wr_data(wr_data0), .wr_valid(wr_valid0),
        .wr_ready(wr_ready0), .tx(tx0), .tx_busy(tx_busy0),
        .fifo_count(fifo_count0), .overflow(overflow0)
    );

    uart_tx_fifo #(
        .CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_e (
        .CLK(CLK), .reset_n(reset_n), .wr_data(wr_data_e), .wr_valid(wr_valid_e),
        .wr_ready(wr_ready_e), .tx(tx_e), .tx_busy(tx_busy_e),
        .fifo_count(fifo_count_e), .overflow(overflow_e)
    );

    uart_tx_fifo #(
        .CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_o (
        .CLK(CLK), .reset_n(reset_n), .wr_data(wr_data_o), .wr_valid(wr_valid_o),
        .wr_ready(wr_ready_o), .tx(tx_o), .tx_busy(tx_busy_o),
        .fifo_count(fifo_count_o), .overflow(overflow_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decodes one 8N1 frame on tx0 by sampling bit centres; returns got=0 if no start bit appears.
    task automatic recv_byte(input int limit, output logic [7:0] data,
                             output logic stop_bit, output logic got);
        got      = 1'b0;
        data     = '0;
        stop_bit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (tx0 === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            repeat (18) @(negedge CLK);
            data[0] = tx0;
            for (int j = 1; j < 8; j++) begin
                repeat (12) @(negedge CLK);
                data[j] = tx0;
            end
            repeat (12) @(negedge CLK);
            stop_bit = tx0;
            repeat (5) @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        logic [8:0] got0, got_e, got_o;
        $display("[TB] reset hold with toggling inputs");
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            got0  = {tx0, tx_busy0, wr_ready0, fifo_count0, overflow0};
            got_e = {tx_e, tx_busy_e, wr_ready_e, fifo_count_e, overflow_e};
            got_o = {tx_o, tx_busy_o, wr_ready_o, fifo_count_o, overflow_o};
            n_compared++;
            if ({got0, got_e, got_o} !== {RESET_VEC, RESET_VEC, RESET_VEC}) begin
                n_mismatched++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b %b %b expected %b", i, got0, got_e, got_o, RESET_VEC);
            end
            wr_data0   = 8'($urandom);
            wr_valid0  = 1'($urandom);
            wr_data_e  = 8'($urandom);
            wr_valid_e = 1'($urandom);
            wr_data_o  = 8'($urandom);
            wr_valid_o = 1'($urandom);
        end
        @(negedge CLK);
        wr_valid0  = 1'b0;
        wr_valid_e = 1'b0;
        wr_valid_o = 1'b0;
        reset_n    = 1'b1;
        repeat (2) @(negedge CLK);
        got0 = {tx0, tx_busy0, wr_ready0, fifo_count0, overflow0};
        n_compared++;
        if (got0 !== RESET_VEC) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_release: got %b expected %b", got0, RESET_VEC);
        end
    endtask

    task automatic test_single_frame;
        logic [9:0]  frame;
        logic [11:0] seen;
        int          busy_cycles;
        frame       = {1'b1, 8'h43, 1'b0};
        busy_cycles = 0;
        $display("[TB] single 8N1 frame 0x43");
        @(negedge CLK);
        wr_data0  = 8'h43;
        wr_valid0 = 1'b1;
        @(negedge CLK);
        wr_valid0 = 1'b0;
        wr_data0  = 8'hBC;
        n_compared++;
        if ({tx0, tx_busy0, fifo_count0} !== {1'b1, 1'b0, 5'd1}) begin
            n_mismatched++;
            $display("[TB] FAIL single_pre_start: got %b expected %b", {tx0, tx_busy0, fifo_count0}, {1'b1, 1'b0, 5'd1});
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge CLK);
                seen[c] = tx0;
                if (tx_busy0 === 1'b1) busy_cycles++;
            end
            n_compared++;
            if (seen !== {12{frame[b]}}) begin
                n_mismatched++;
                $display("[TB] FAIL single_bit%0d: got %b expected %b", b, seen, {12{frame[b]}});
            end
        end
        @(negedge CLK);
        n_compared++;
        if ({tx0, tx_busy0} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL single_end_idle: got %b expected 10", {tx0, tx_busy0});
        end
        n_compared++;
        if (busy_cycles != 120) begin
            n_mismatched++;
            $display("[TB] FAIL single_busy_len: got %0d expected 120", busy_cycles);
        end
    endtask

    task automatic test_back_to_back;
        logic       line_tx [400];
        logic       line_busy [400];
        logic [4:0] peak;
        logic [7:0] dec;
        logic [7:0] exp_words [3];
        int         busy_in, busy_all, base;
        exp_words[0] = 8'h41;
        exp_words[1] = 8'h42;
        exp_words[2] = 8'h43;
        peak     = '0;
        busy_in  = 0;
        busy_all = 0;
        $display("[TB] back-to-back A,B,C");
        @(negedge CLK);
        wr_data0  = 8'h41;
        wr_valid0 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            line_tx[i]   = tx0;
            line_busy[i] = tx_busy0;
            if (fifo_count0 > peak) peak = fifo_count0;
            if (i == 0) wr_data0 = 8'h42;
            else if (i == 1) wr_data0 = 8'h43;
            else if (i == 2) wr_valid0 = 1'b0;
        end
        n_compared++;
        if (peak !== 5'd2) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_peak_count: got %0d expected 2", peak);
        end
        for (int i = 0; i < 400; i++) begin
            if (line_busy[i] === 1'b1) begin
                busy_all++;
                if (i >= 1 && i <= 360) busy_in++;
            end
        end
        n_compared++;
        if (busy_in != 360 || busy_all != 360) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_busy: got %0d in-window %0d total expected 360 360", busy_in, busy_all);
        end
        n_compared++;
        if ({line_tx[120], line_tx[121], line_tx[240], line_tx[241]} !== 4'b1010) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_no_gap: got %b expected 1010",
                     {line_tx[120], line_tx[121], line_tx[240], line_tx[241]});
        end
        for (int k = 0; k < 3; k++) begin
            base = 1 + 120 * k;
            for (int j = 0; j < 8; j++) dec[j] = line_tx[base + 12 * (j + 1) + 6];
            n_compared++;
            if ({line_tx[base + 6], dec, line_tx[base + 114]} !== {1'b0, exp_words[k], 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_frame%0d: got %b expected %b", k,
                         {line_tx[base + 6], dec, line_tx[base + 114]}, {1'b0, exp_words[k], 1'b1});
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] rx_words [17];
        logic [7:0] d;
        logic       s, g, g_extra;
        logic [4:0] count_at_fall;
        int         fall_idx, n_got, bad_stops;
        fall_idx      = -1;
        count_at_fall = '0;
        n_got         = 0;
        bad_stops     = 0;
        g_extra       = 1'b0;
        $display("[TB] FIFO fill with 20 pushes");
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge CLK);
                    if (fall_idx < 0 && wr_ready0 === 1'b0) begin
                        fall_idx      = i;
                        count_at_fall = fifo_count0;
                    end
                    wr_data0  = 8'(i);
                    wr_valid0 = 1'b1;
                end
                @(negedge CLK);
                wr_valid0 = 1'b0;
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    recv_byte(300, d, s, g);
                    if (!g) break;
                    rx_words[k] = d;
                    n_got++;
                    if (s !== 1'b1) bad_stops++;
                end
                recv_byte(300, d, s, g_extra);
            end
        join
        n_compared++;
        if (fall_idx != 17 || count_at_fall !== 5'd16) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_ready_fall: got cycle %0d count %0d expected cycle 17 count 16", fall_idx, count_at_fall);
        end
        n_compared++;
        if (n_got != 17 || g_extra !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_frame_count: got %0d frames extra %b expected 17 frames extra 0", n_got, g_extra);
        end
        for (int k = 0; k < n_got; k++) begin
            n_compared++;
            if (rx_words[k] !== 8'(k)) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_word%0d: got %h expected %h", k, rx_words[k], 8'(k));
            end
        end
        n_compared++;
        if (bad_stops != 0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_stop_bits: got %0d bad stops expected 0", bad_stops);
        end
        n_compared++;
        if ({overflow0, fifo_count0, tx_busy0, wr_ready0} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_final: got %b expected %b", {overflow0, fifo_count0, tx_busy0, wr_ready0}, {1'b1, 5'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_parity;
        logic [11:0] frame_e;
        logic [10:0] frame_o;
        logic [11:0] seen;
        int          busy_cycles;
        frame_e = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
        frame_o = {1'b1, 1'b0, 8'h07, 1'b0};
        $display("[TB] even parity 2 stop, then odd parity, word 0x07");
        busy_cycles = 0;
        @(negedge CLK);
        wr_data_e  = 8'h07;
        wr_valid_e = 1'b1;
        @(negedge CLK);
        wr_valid_e = 1'b0;
        for (int b = 0; b < 12; b++) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge CLK);
                seen[c] = tx_e;
                if (tx_busy_e === 1'b1) busy_cycles++;
            end
            n_compared++;
            if (seen !== {12{frame_e[b]}}) begin
                n_mismatched++;
                $display("[TB] FAIL even_bit%0d: got %b expected %b", b, seen, {12{frame_e[b]}});
            end
        end
        @(negedge CLK);
        n_compared++;
        if (busy_cycles != 144 || {tx_e, tx_busy_e} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL even_busy: got %0d cycles end %b expected 144 cycles end 10", busy_cycles, {tx_e, tx_busy_e});
        end
        busy_cycles = 0;
        @(negedge CLK);
        wr_data_o  = 8'h07;
        wr_valid_o = 1'b1;
        @(negedge CLK);
        wr_valid_o = 1'b0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge CLK);
                seen[c] = tx_o;
                if (tx_busy_o === 1'b1) busy_cycles++;
            end
            n_compared++;
            if (seen !== {12{frame_o[b]}}) begin
                n_mismatched++;
                $display("[TB] FAIL odd_bit%0d: got %b expected %b", b, seen, {12{frame_o[b]}});
            end
        end
        @(negedge CLK);
        n_compared++;
        if (busy_cycles != 132 || {tx_o, tx_busy_o} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL odd_busy: got %0d cycles end %b expected 132 cycles end 10", busy_cycles, {tx_o, tx_busy_o});
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [8:0] got0;
        logic [7:0] d;
        logic       s, g;
        int         idle_bad;
        idle_bad = 0;
        $display("[TB] reset during data bit 3 of 0x55 with 5 words queued");
        @(negedge CLK);
        wr_data0  = 8'h55;
        wr_valid0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            wr_data0 = 8'h10 + 8'(i);
        end
        @(negedge CLK);
        wr_valid0 = 1'b0;
        repeat (50) @(negedge CLK);
        n_compared++;
        if ({tx0, fifo_count0} !== {1'b0, 5'd5}) begin
            n_mismatched++;
            $display("[TB] FAIL mid_frame_state: got %b expected %b", {tx0, fifo_count0}, {1'b0, 5'd5});
        end
        #2;
        reset_n = 1'b0;
        #1;
        got0 = {tx0, tx_busy0, wr_ready0, fifo_count0, overflow0};
        n_compared++;
        if (got0 !== RESET_VEC) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got %b expected %b", got0, RESET_VEC);
        end
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (tx0 !== 1'b1 || tx_busy0 !== 1'b0) idle_bad++;
        end
        n_compared++;
        if (idle_bad != 0) begin
            n_mismatched++;
            $display("[TB] FAIL no_frames_after_reset: got %0d active cycles expected 0", idle_bad);
        end
        @(negedge CLK);
        wr_data0  = 8'h5A;
        wr_valid0 = 1'b1;
        @(negedge CLK);
        wr_valid0 = 1'b0;
        recv_byte(50, d, s, g);
        n_compared++;
        if ({g, d, s} !== {1'b1, 8'h5A, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL clean_frame_5A: got %b expected %b", {g, d, s}, {1'b1, 8'h5A, 1'b1});
        end
        @(negedge CLK);
        n_compared++;
        if ({fifo_count0, tx_busy0} !== {5'd0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL post_5A_idle: got %b expected %b", {fifo_count0, tx_busy0}, {5'd0, 1'b0});
        end
    endtask

    initial begin
        reset_n    = 1'b1;
        wr_data0   = '0;
        wr_data_e  = '0;
        wr_data_o  = '0;
        wr_valid0  = 1'b0;
        wr_valid_e = 1'b0;
        wr_valid_o = 1'b0;
        #1;
        reset_n = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
